// File: rtl/ifu_pkg.sv
// Shared constants and field helpers for the instruction fetch unit.
package ifu_pkg;

  localparam int WORD_BYTES   = 4;
  localparam int IMM16_MSB    = 15;
  localparam int IMM16_LSB    = 0;
  localparam int TARGET26_MSB = 25;
  localparam int TARGET26_LSB = 0;

  // Word-aligned low 28 bits of a jump target.
  function automatic logic [27:0] jump_low(input logic [25:0] target26);
    return {target26, 2'b00};
  endfunction

  // Branch displacement in bytes: sign-extended imm16 scaled by the word size.
  function automatic logic signed [31:0] branch_offset(input logic [15:0] imm16);
    return {{14{imm16[15]}}, imm16, 2'b00};
  endfunction

endpackage

// File: rtl/ifu_imem.sv
// Instruction memory: DEPTH x 32, synchronous read with one cycle of latency.
// Contents are preloaded hierarchically through the array named mem.
module ifu_imem #(
  parameter int DEPTH = 1024,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             rd_en_i,
  input  logic [IDX_W-1:0] rd_addr_i,
  output logic [31:0]      rd_data_o
);

  logic [31:0] mem [DEPTH];

  // NOTE: storage arrays get no reset branch; flops that hold data qualified
  // by separate valid state do not need one, and a reset would prevent RAM mapping.
  // NOTE: clocked state is always written with <=, so every reader sees the
  // pre-edge value regardless of process ordering.
  always_ff @(posedge clock) begin
    if (rd_en_i) rd_data_o <= mem[rd_addr_i];
  end

endmodule

// File: rtl/ifu_queue.sv
// Instruction fetch unit: PC, synchronous imem and a fetch queue with branch/jump redirect.
// Optional build macro IFU_PERF_EN adds the redirect_count output.
module ifu_queue
  import ifu_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    IMEM_DEPTH  = 1024,
  parameter int                    QUEUE_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                  clock,
  input  logic                  start_n,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [31:0]           instruction,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  input  logic                  branch,
  input  logic                  zero,
  input  logic                  jump
`ifdef IFU_PERF_EN
  ,
  output logic [31:0]           redirect_count
`endif
);

  localparam int IDX_W = $clog2(IMEM_DEPTH);
  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [31:0]           instruction;
  } entry_t;

  entry_t                queue_q [QUEUE_DEPTH];
  logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  inflight_q, inflight_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] issued_pc_q, issued_pc_d;

  entry_t                head;
  logic [31:0]           rd_data;
  logic                  accept, taken, issue, push, pop;
  logic [ADDR_WIDTH-1:0] pc4, jump_target, branch_target, redirect_pc;
  logic [31:0]           jump_word;

  assign head        = queue_q[head_q];
  assign instr_valid = (count_q != '0);
  assign instruction = instr_valid ? head.instruction : '0;
  assign instr_pc    = instr_valid ? head.pc : '0;

  assign accept = instr_valid & instr_ready;
  assign taken  = accept & (jump | (branch & zero));
  // A redirect suppresses issue so the first fetch at the target starts next cycle.
  assign issue  = ~taken & ((count_q + CNT_W'(inflight_q)) < CNT_W'(QUEUE_DEPTH));
  assign push   = inflight_q & ~taken;
  assign pop    = accept & ~taken;

  assign pc4           = head.pc + ADDR_WIDTH'(WORD_BYTES);
  assign jump_word     = {pc4[ADDR_WIDTH-1 -: 4],
                          jump_low(head.instruction[TARGET26_MSB:TARGET26_LSB])};
  assign jump_target   = ADDR_WIDTH'(jump_word);
  assign branch_target = pc4 + ADDR_WIDTH'(branch_offset(head.instruction[IMM16_MSB:IMM16_LSB]));
  assign redirect_pc   = jump ? jump_target : branch_target;

  // NOTE: every variable gets its default before the branches, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    fetch_pc_d  = fetch_pc_q;
    issued_pc_d = issued_pc_q;
    inflight_d  = issue;
    if (taken) begin
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      fetch_pc_d = redirect_pc;
    end else begin
      if (push) tail_d = tail_q + PTR_W'(1);
      if (pop)  head_d = head_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      if (issue) begin
        issued_pc_d = fetch_pc_q;
        fetch_pc_d  = fetch_pc_q + ADDR_WIDTH'(WORD_BYTES);
      end
    end
  end

  always_ff @(posedge clock or negedge start_n) begin
    if (!start_n) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      inflight_q  <= 1'b0;
      fetch_pc_q  <= RESET_PC;
      issued_pc_q <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      inflight_q  <= inflight_d;
      fetch_pc_q  <= fetch_pc_d;
      issued_pc_q <= issued_pc_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) queue_q[tail_q] <= '{pc: issued_pc_q, instruction: rd_data};
  end

  ifu_imem #(
    .DEPTH (IMEM_DEPTH)
  ) IMEM (
    .clock     (clock),
    .rd_en_i   (issue),
    .rd_addr_i (fetch_pc_q[IDX_W+1:2]),
    .rd_data_o (rd_data)
  );

`ifdef IFU_PERF_EN
  logic [31:0] redirect_count_q;

  always_ff @(posedge clock or negedge start_n) begin
    if (!start_n)   redirect_count_q <= '0;
    else if (taken) redirect_count_q <= redirect_count_q + 32'd1;
  end

  assign redirect_count = redirect_count_q;
`endif

endmodule
